key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the stable-sample count needed to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of held cycles after the accepted press before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the number of cycles between later auto-repeat pulses.
REQ-004 Sys_CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Sys_RST  input  1  is a synchronous, active-low reset.
REQ-006 Key_In  input  2  carries raw asynchronous push-button levels, active-low (0 = pressed).
REQ-007 Repeat_En  input  1  enables auto-repeat pulses for both keys when 1.
REQ-008 Key_Out  output  2  gives one-cycle active-high event pulses per key; this is the consumer-facing event bus.
REQ-009 Key_Level  output  2  gives the debounced pressed level per key, active-high.

Function
REQ-010 Each Key_In bit SHALL pass through a 2-flop synchronizer before any use; the channels SHALL be fully independent.
REQ-011 Each channel SHALL implement an FSM with the states IDLE, PRESS_DB, HELD, REPEAT and REL_DB.
REQ-012 IDLE: on synced low, go to PRESS_DB with the counter cleared; otherwise stay.
REQ-013 PRESS_DB: counter +1 per low sample; any high sample returns to IDLE (no pulse); at count DEBOUNCE_CYCLES-1, go to HELD, pulse Key_Out for 1 cycle, set Key_Level=1.
REQ-014 HELD: on synced high, go to REL_DB; else, if Repeat_En and the hold counter reaches REPEAT_DELAY-1, pulse and go to REPEAT.
REQ-015 REPEAT: pulse every REPEAT_PERIOD cycles while low and Repeat_En=1; Repeat_En=0 returns to HELD with the hold counter frozen at its terminal value (no pulses); high goes to REL_DB.
REQ-016 REL_DB: a low sample returns to HELD with the hold counter cleared and no pulse; DEBOUNCE_CYCLES consecutive high samples go to IDLE and clear Key_Level.
REQ-017 Latency: a press stable from edge t0 SHALL assert Key_Out at edge t0+2+DEBOUNCE_CYCLES.
REQ-018 Key_Level SHALL stay 1 from the accepted press until the accepted release.
REQ-019 Key_Out SHALL never stay high for two consecutive cycles on the same bit.
REQ-020 Counters SHALL saturate, never wrap; each counter width SHALL be the $clog2 of its largest parameter.
REQ-021 Both keys accepted on the same edge SHALL pulse together (Key_Out=2'b11); no arbitration happens here.

Reset
REQ-022 With Sys_RST=0 at an edge: every FSM goes to IDLE, all counters and synchronizer flops clear (synchronizers load 1 = released), Key_Out=2'b00, Key_Level=2'b00.
REQ-023 Reset mid-debounce or mid-repeat SHALL abort with no pulse; a key still held after reset SHALL require a full DEBOUNCE_CYCLES before its pulse.

Structure
REQ-024 The FSM state encodings and the default timing constants SHALL live in the shared package key_pkg.
REQ-025 One sub-module, key_debounce_ch (synchronizer, FSM and counters for one key), SHALL be instantiated twice.
REQ-026 Target size: about 150-250 lines of RTL in total.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Key_In[0] low at t0, held for 20 cycles, Repeat_En=0 -> exactly one Key_Out[0] pulse at t0+6; Key_Level[0]=1 from t0+6.
REQ-028 Key_In[1] bounces 0/1 every 2 cycles for 30 cycles, then stays high -> no Key_Out[1] pulse; Key_Level[1] stays 0.
REQ-029 Key_In[0] held low for 30 cycles with Repeat_En=1 -> pulses at t0+6, t0+16, t0+19, t0+22, and so on every 3 cycles until release.
REQ-030 Both keys pressed on the same edge -> Key_Out=2'b11 for one cycle, and never 2'b01 or 2'b10 on adjacent cycles.
REQ-031 Sys_RST=0 at t0+4 during a press held throughout -> no pulse at t0+6; after release of reset at t0+5, the pulse arrives at t0+5+2+4.
REQ-032 Release glitch: high for 2 cycles during HELD -> no second pulse, and Key_Level stays 1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared state encodings, default timing constants and counter sizing for the key debouncer.
package key_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS_DB = 3'd1;
    localparam logic [2:0] ST_HELD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    // $clog2 of the terminal parameter, kept at least one bit wide for tiny parameters.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key event bus: raw key levels and repeat enable in, debounced events and levels out.
interface key_debounce_if;

    logic [1:0] Key_In;
    logic       Repeat_En;
    logic [1:0] Key_Out;
    logic [1:0] Key_Level;

    modport master (output Key_In, output Repeat_En, input Key_Out, input Key_Level);
    modport slave  (input Key_In, input Repeat_En, output Key_Out, output Key_Level);

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce/auto-repeat FSM and saturating counters.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic Sys_CLK,
    input  logic Sys_RST,
    input  logic key_in,
    input  logic repeat_en,
    output logic key_out,
    output logic key_level
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(REPEAT_DELAY);
    localparam int unsigned REP_W  = cnt_width(REPEAT_PERIOD);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic [1:0]        sync;
    logic [2:0]        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              pressed;

    assign pressed = ~sync[1];

    // Pulses are written as ~key_out so a pulse can never last two cycles, even with tiny periods.
    always_ff @(posedge Sys_CLK) begin
        if (!Sys_RST) begin
            sync      <= 2'b11;
            state     <= ST_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            key_out   <= 1'b0;
            key_level <= 1'b0;
        end else begin
            sync    <= {sync[0], key_in};
            key_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        state  <= ST_PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!pressed) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_HELD;
                        hold_cnt  <= '0;
                        key_out   <= ~key_out;
                        key_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!pressed) begin
                        state  <= ST_REL_DB;
                        db_cnt <= '0;
                    end else if (repeat_en && hold_cnt == HOLD_LAST) begin
                        state   <= ST_REPEAT;
                        rep_cnt <= '0;
                        key_out <= ~key_out;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                // hold_cnt stays at HOLD_LAST here, so dropping back to HELD re-arms the repeat at once.
                ST_REPEAT: begin
                    if (!pressed) begin
                        state  <= ST_REL_DB;
                        db_cnt <= '0;
                    end else if (!repeat_en) begin
                        state <= ST_HELD;
                    end else if (rep_cnt == REP_LAST) begin
                        rep_cnt <= '0;
                        key_out <= ~key_out;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                ST_REL_DB: begin
                    if (pressed) begin
                        state    <= ST_HELD;
                        hold_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_IDLE;
                        key_level <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Two-key push-button debouncer with optional auto-repeat; the keys are handled independently.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic          Sys_CLK,
    input  logic          Sys_RST,
    key_debounce_if.slave bus
);

    logic [1:0] key_out;
    logic [1:0] key_level;

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch0 (
        .Sys_CLK   (Sys_CLK),
        .Sys_RST   (Sys_RST),
        .key_in    (bus.Key_In[0]),
        .repeat_en (bus.Repeat_En),
        .key_out   (key_out[0]),
        .key_level (key_level[0])
    );

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch1 (
        .Sys_CLK   (Sys_CLK),
        .Sys_RST   (Sys_RST),
        .key_in    (bus.Key_In[1]),
        .repeat_en (bus.Repeat_En),
        .key_out   (key_out[1]),
        .key_level (key_level[1])
    );

    assign bus.Key_Out   = key_out;
    assign bus.Key_Level = key_level;

endmodule
